// File: rtl/rx_frame_decoder.sv
// Receive-side frame decoder: START/LEN/payload/CSUM/END framing with a
// ping-pong payload store so the last good frame stays readable while the next arrives.
module rx_frame_decoder #(
    parameter int          DATA_W      = 8,
    parameter int          MAX_BYTES   = 16,
    parameter int          IDX_W       = 4,
    parameter int          TIMEOUT_CYC = 100,
    parameter logic [7:0]  SP_START    = 8'h7E,
    parameter logic [7:0]  SP_END      = 8'h7D
) (
    input  logic              ct_rxclk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W:0]   in_data,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data,
    output logic [7:0]        frame_len,
    output logic              frame_valid,
    output logic              busy,
    output logic              err_pulse,
    output logic [2:0]        err_code,
    output logic [7:0]        err_cnt
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        BCNT = 3'd1,
        BODY = 3'd2,
        CSUM = 3'd3,
        TAIL = 3'd4
    } state_t;

    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMR_W-1:0]  TMR_LAST   = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [DATA_W-1:0] START_CODE = DATA_W'(SP_START);
    localparam logic [DATA_W-1:0] END_CODE   = DATA_W'(SP_END);
    localparam logic [DATA_W-1:0] MAX_LEN    = DATA_W'(MAX_BYTES);

    localparam logic [2:0] ERR_TIMEOUT  = 3'd1;
    localparam logic [2:0] ERR_LENGTH   = 3'd2;
    localparam logic [2:0] ERR_PROTOCOL = 3'd3;
    localparam logic [2:0] ERR_CHECKSUM = 3'd4;
    localparam logic [2:0] ERR_RESYNC   = 3'd5;

    state_t              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [7:0]          len_q, len_d;
    logic [DATA_W-1:0]   sum_q, sum_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic                bank_sel_q;
    logic [7:0]          frame_len_q;
    logic                frame_valid_q;
    logic                err_pulse_q;
    logic [2:0]          err_code_q;
    logic [7:0]          err_cnt_q;
    logic [DATA_W-1:0]   mem_q [2][MAX_BYTES];

    logic                is_ctrl;
    logic [DATA_W-1:0]   val;
    logic                abort;
    logic [2:0]          abort_code;
    logic                commit;
    logic                wr_en;

    assign is_ctrl = in_data[DATA_W];
    assign val     = in_data[DATA_W-1:0];

    // NOTE: every signal driven here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        sum_d      = sum_q;
        timer_d    = timer_q;
        abort      = 1'b0;
        abort_code = 3'd0;
        commit     = 1'b0;
        wr_en      = 1'b0;

        if (state_q == IDLE) begin
            timer_d = '0;
            if (in_valid && is_ctrl && val == START_CODE) begin
                state_d = BCNT;
                cnt_d   = '0;
                sum_d   = '0;
            end
        end else if (in_valid) begin
            timer_d = '0;
            if (is_ctrl && val == START_CODE) begin
                // Resync: drop the partial frame but treat this START as a fresh one.
                abort      = 1'b1;
                abort_code = ERR_RESYNC;
                state_d    = BCNT;
                cnt_d      = '0;
                sum_d      = '0;
            end else begin
                unique case (state_q)
                    BCNT: begin
                        if (is_ctrl) begin
                            abort      = 1'b1;
                            abort_code = ERR_PROTOCOL;
                        end else if (val > MAX_LEN) begin
                            abort      = 1'b1;
                            abort_code = ERR_LENGTH;
                        end else begin
                            len_d   = 8'(val);
                            state_d = (val == '0) ? CSUM : BODY;
                        end
                    end
                    BODY: begin
                        if (is_ctrl) begin
                            abort      = 1'b1;
                            abort_code = ERR_PROTOCOL;
                        end else begin
                            wr_en = 1'b1;
                            sum_d = sum_q + val;
                            cnt_d = cnt_q + 8'd1;
                            if (cnt_q + 8'd1 == len_q) begin
                                state_d = CSUM;
                            end
                        end
                    end
                    CSUM: begin
                        if (is_ctrl) begin
                            abort      = 1'b1;
                            abort_code = ERR_PROTOCOL;
                        end else if (val != sum_q) begin
                            abort      = 1'b1;
                            abort_code = ERR_CHECKSUM;
                        end else begin
                            state_d = TAIL;
                        end
                    end
                    TAIL: begin
                        if (is_ctrl && val == END_CODE) begin
                            commit  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            abort      = 1'b1;
                            abort_code = ERR_PROTOCOL;
                        end
                    end
                    default: state_d = IDLE;
                endcase
                if (abort) begin
                    state_d = IDLE;
                end
            end
        end else begin
            timer_d = timer_q + 1'b1;
            if (timer_q == TMR_LAST) begin
                abort      = 1'b1;
                abort_code = ERR_TIMEOUT;
                state_d    = IDLE;
                timer_d    = '0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge ct_rxclk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            len_q         <= '0;
            sum_q         <= '0;
            timer_q       <= '0;
            bank_sel_q    <= 1'b0;
            frame_len_q   <= '0;
            frame_valid_q <= 1'b0;
            err_pulse_q   <= 1'b0;
            err_code_q    <= '0;
            err_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            len_q         <= len_d;
            sum_q         <= sum_d;
            timer_q       <= timer_d;
            frame_valid_q <= commit;
            err_pulse_q   <= abort;
            if (commit) begin
                bank_sel_q  <= ~bank_sel_q;
                frame_len_q <= len_q;
            end
            if (abort) begin
                err_code_q <= abort_code;
                if (err_cnt_q != 8'hFF) begin
                    err_cnt_q <= err_cnt_q + 8'd1;
                end
            end
        end
    end

    // NOTE: the payload banks are deliberately not reset; stale contents are
    // hidden by the frame_len mask on the read port.
    always_ff @(posedge ct_rxclk) begin
        if (wr_en) begin
            mem_q[~bank_sel_q][cnt_q[IDX_W-1:0]] <= val;
        end
    end

    assign rd_data     = (8'(rd_idx) < frame_len_q) ? mem_q[bank_sel_q][rd_idx] : '0;
    assign frame_len   = frame_len_q;
    assign frame_valid = frame_valid_q;
    assign busy        = (state_q != IDLE);
    assign err_pulse   = err_pulse_q;
    assign err_code    = err_code_q;
    assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_rx_frame_decoder.sv
// Directed bench for rx_frame_decoder: hand-computed frames, aborts, timeout
// boundary, resync, mid-frame reset and error-counter saturation.
module tb_rx_frame_decoder;

    localparam int DATA_W      = 8;
    localparam int MAX_BYTES   = 16;
    localparam int IDX_W       = 4;
    localparam int TIMEOUT_CYC = 100;

    logic              ct_rxclk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic [DATA_W:0]   in_data;
    logic [IDX_W-1:0]  rd_idx;
    logic [DATA_W-1:0] rd_data;
    logic [7:0]        frame_len;
    logic              frame_valid;
    logic              busy;
    logic              err_pulse;
    logic [2:0]        err_code;
    logic [7:0]        err_cnt;

    int checks = 0;
    int errors = 0;

    rx_frame_decoder #(
        .DATA_W      (DATA_W),
        .MAX_BYTES   (MAX_BYTES),
        .IDX_W       (IDX_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .ct_rxclk    (ct_rxclk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .rd_idx      (rd_idx),
        .rd_data     (rd_data),
        .frame_len   (frame_len),
        .frame_valid (frame_valid),
        .busy        (busy),
        .err_pulse   (err_pulse),
        .err_code    (err_code),
        .err_cnt     (err_cnt)
    );

    always #5 ct_rxclk = ~ct_rxclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents one symbol for exactly one rising edge, returns 1 time unit after it.
    task automatic send(input logic ctrl, input logic [7:0] v);
        in_valid = 1'b1;
        in_data  = {ctrl, v};
        @(posedge ct_rxclk);
        #1;
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge ct_rxclk);
            #1;
        end
    endtask

    task automatic read(input string tag, input int idx, input logic [7:0] exp);
        rd_idx = IDX_W'(idx);
        #1;
        check(tag, 32'(rd_data), 32'(exp));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"},   32'(busy),        32'h0);
        check({tag, "_len"},    32'(frame_len),   32'h0);
        check({tag, "_fvalid"}, 32'(frame_valid), 32'h0);
        check({tag, "_epulse"}, 32'(err_pulse),   32'h0);
        check({tag, "_ecode"},  32'(err_code),    32'h0);
        check({tag, "_ecnt"},   32'(err_cnt),     32'h0);
        read({tag, "_rd0"}, 0, 8'h00);
    endtask

    initial begin
        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        rd_idx   = '0;
        idle(2);
        check_reset_values("reset");
        @(negedge ct_rxclk);
        reset = 1'b1;
        idle(1);

        // Basic frame: sum 0x11+0x22+0x33 = 0x66
        send(1'b1, 8'h7E);
        check("start_busy", 32'(busy), 32'h1);
        send(1'b0, 8'h03);
        send(1'b0, 8'h11);
        send(1'b0, 8'h22);
        send(1'b0, 8'h33);
        send(1'b0, 8'h66);
        check("pre_end_fvalid", 32'(frame_valid), 32'h0);
        send(1'b1, 8'h7D);
        check("a_fvalid", 32'(frame_valid), 32'h1);
        check("a_len", 32'(frame_len), 32'h3);
        check("a_busy", 32'(busy), 32'h0);
        read("a_rd0", 0, 8'h11);
        read("a_rd1", 1, 8'h22);
        read("a_rd2", 2, 8'h33);
        read("a_rd3", 3, 8'h00);
        idle(1);
        check("a_fvalid_drop", 32'(frame_valid), 32'h0);

        // Bad checksum: correct would be 0xAB
        send(1'b1, 8'h7E);
        send(1'b0, 8'h02);
        send(1'b0, 8'hAA);
        send(1'b0, 8'h01);
        send(1'b0, 8'h00);
        check("b_epulse", 32'(err_pulse), 32'h1);
        check("b_ecode", 32'(err_code), 32'h4);
        check("b_ecnt", 32'(err_cnt), 32'h1);
        check("b_busy", 32'(busy), 32'h0);
        check("b_len_kept", 32'(frame_len), 32'h3);
        read("b_rd0_kept", 0, 8'h11);
        read("b_rd1_kept", 1, 8'h22);
        idle(1);
        check("b_epulse_drop", 32'(err_pulse), 32'h0);

        // Checksum wraps modulo 256: 0xF0+0x20 = 0x10
        send(1'b1, 8'h7E);
        send(1'b0, 8'h02);
        send(1'b0, 8'hF0);
        send(1'b0, 8'h20);
        send(1'b0, 8'h10);
        send(1'b1, 8'h7D);
        check("w_fvalid", 32'(frame_valid), 32'h1);
        check("w_len", 32'(frame_len), 32'h2);
        read("w_rd0", 0, 8'hF0);
        read("w_rd1", 1, 8'h20);
        read("w_rd2", 2, 8'h00);

        // Length one past capacity
        send(1'b1, 8'h7E);
        send(1'b0, 8'(MAX_BYTES + 1));
        check("len_epulse", 32'(err_pulse), 32'h1);
        check("len_ecode", 32'(err_code), 32'h2);
        check("len_busy", 32'(busy), 32'h0);
        check("len_ecnt", 32'(err_cnt), 32'h2);
        check("len_len_kept", 32'(frame_len), 32'h2);

        // Empty frame
        send(1'b1, 8'h7E);
        send(1'b0, 8'h00);
        send(1'b0, 8'h00);
        send(1'b1, 8'h7D);
        check("z_fvalid", 32'(frame_valid), 32'h1);
        check("z_len", 32'(frame_len), 32'h0);
        read("z_rd0", 0, 8'h00);

        // Premature END inside the body
        send(1'b1, 8'h7E);
        send(1'b0, 8'h01);
        send(1'b1, 8'h7D);
        check("p_ecode", 32'(err_code), 32'h3);
        check("p_ecnt", 32'(err_cnt), 32'h3);
        check("p_busy", 32'(busy), 32'h0);

        // Timeout after exactly TIMEOUT_CYC idle edges
        send(1'b1, 8'h7E);
        send(1'b0, 8'h04);
        send(1'b0, 8'h01);
        send(1'b0, 8'h02);
        idle(TIMEOUT_CYC - 1);
        check("t_busy_before", 32'(busy), 32'h1);
        check("t_epulse_before", 32'(err_pulse), 32'h0);
        idle(1);
        check("t_epulse", 32'(err_pulse), 32'h1);
        check("t_ecode", 32'(err_code), 32'h1);
        check("t_busy", 32'(busy), 32'h0);
        check("t_ecnt", 32'(err_cnt), 32'h4);

        // Symbol on the limit edge wins over the timeout
        send(1'b1, 8'h7E);
        send(1'b0, 8'h01);
        idle(TIMEOUT_CYC - 1);
        send(1'b0, 8'h07);
        check("tl_epulse", 32'(err_pulse), 32'h0);
        check("tl_busy", 32'(busy), 32'h1);
        idle(TIMEOUT_CYC - 1);
        send(1'b0, 8'h07);
        send(1'b1, 8'h7D);
        check("tl_fvalid", 32'(frame_valid), 32'h1);
        check("tl_len", 32'(frame_len), 32'h1);
        check("tl_ecnt", 32'(err_cnt), 32'h4);
        read("tl_rd0", 0, 8'h07);

        // Resync: START mid-frame restarts immediately
        send(1'b1, 8'h7E);
        send(1'b0, 8'h02);
        send(1'b0, 8'hAA);
        send(1'b1, 8'h7E);
        check("r_epulse", 32'(err_pulse), 32'h1);
        check("r_ecode", 32'(err_code), 32'h5);
        check("r_busy", 32'(busy), 32'h1);
        check("r_ecnt", 32'(err_cnt), 32'h5);
        send(1'b0, 8'h01);
        send(1'b0, 8'h05);
        send(1'b0, 8'h05);
        send(1'b1, 8'h7D);
        check("r_fvalid", 32'(frame_valid), 32'h1);
        check("r_len", 32'(frame_len), 32'h1);
        read("r_rd0", 0, 8'h05);
        read("r_rd1", 1, 8'h00);

        // Asynchronous reset in the middle of a frame
        send(1'b1, 8'h7E);
        send(1'b0, 8'h03);
        send(1'b0, 8'h01);
        #2;
        reset = 1'b0;
        #1;
        check_reset_values("midrst");
        @(negedge ct_rxclk);
        reset = 1'b1;
        idle(1);
        check("midrst_idle", 32'(busy), 32'h0);

        // Error counter saturation: each START followed by END in BCNT aborts
        for (int i = 0; i < 255; i++) begin
            send(1'b1, 8'h7E);
            send(1'b1, 8'h7D);
        end
        check("sat_255", 32'(err_cnt), 32'hFF);
        send(1'b1, 8'h7E);
        send(1'b1, 8'h7D);
        check("sat_hold", 32'(err_cnt), 32'hFF);
        check("sat_epulse", 32'(err_pulse), 32'h1);
        check("sat_ecode", 32'(err_code), 32'h3);
        check("sat_len_kept", 32'(frame_len), 32'h0);

        reset = 1'b0;
        #1;
        check_reset_values("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
